// File: rtl/signmag_mul_pkg.sv
// Shared types and elaboration helpers for the sequential sign-magnitude multiplier.
package signmag_mul_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} stateT;

  function automatic int countWidth(input int width);
    return $clog2(width + 1);
  endfunction

  function automatic bit paramsLegal(input int width, input int outW, input int ovfW);
    return (outW >= 2 * width + 1) && (ovfW <= 2 * width) && (ovfW >= 1);
  endfunction

endpackage

// File: rtl/shift_add_core.sv
// Radix-2 shift-add datapath: one multiplier bit per clock, WIDTH iterations per product.
module shift_add_core
  import signmag_mul_pkg::*;
#(
  parameter int WIDTH = 7
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     magA,
  input  logic [WIDTH-1:0]     magB,
  output logic [2*WIDTH-1:0]   product,
  output logic                 done
);

  localparam int CW = countWidth(WIDTH);
  localparam logic [CW-1:0] LastCount = CW'(WIDTH);

  logic [2*WIDTH-1:0] accReg;
  logic [2*WIDTH-1:0] mcandReg;
  logic [WIDTH-1:0]   mplierReg;
  logic [CW-1:0]      countReg;
  logic               runReg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      accReg    <= '0;
      mcandReg  <= '0;
      mplierReg <= '0;
      countReg  <= '0;
      runReg    <= 1'b0;
    end else if (start) begin
      accReg    <= '0;
      mcandReg  <= {{WIDTH{1'b0}}, magA};
      mplierReg <= magB;
      countReg  <= '0;
      runReg    <= 1'b1;
    end else if (runReg) begin
      // done is held for one cycle after the last iteration so the FSM can register it
      if (countReg == LastCount) begin
        runReg <= 1'b0;
      end else begin
        if (mplierReg[0]) accReg <= accReg + mcandReg;
        mcandReg  <= mcandReg << 1;
        mplierReg <= mplierReg >> 1;
        countReg  <= countReg + 1'b1;
      end
    end
  end

  assign product = accReg;
  assign done    = runReg && (countReg == LastCount);

endmodule

// File: rtl/signmag_mul_seq.sv
// Sequential sign-magnitude multiplier with valid/ready handshakes, optional
// magnitude saturation and a two's-complement, sign-extended result.
module signmag_mul_seq
  import signmag_mul_pkg::*;
#(
  parameter int WIDTH    = 7,
  parameter int OUT_W    = 32,
  parameter int OVF_W    = 12,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] mag_a,
  input  logic             sign_a,
  input  logic [WIDTH-1:0] mag_b,
  input  logic             sign_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out,
  output logic             sign,
  output logic             overflow,
  output logic             busy
);

  generate
    if (!paramsLegal(WIDTH, OUT_W, OVF_W)) begin : gParamCheck
      $error("signmag_mul_seq: need OUT_W >= 2*WIDTH+1 and 1 <= OVF_W <= 2*WIDTH");
    end
  endgenerate

  localparam logic [2*WIDTH-1:0] MaxMag = (2*WIDTH)'((64'd1 << OVF_W) - 64'd1);

  stateT stateReg, stateNext;

  logic               start;
  logic               coreDone;
  logic [2*WIDTH-1:0] coreProduct;
  logic               signReg;
  logic [OUT_W-1:0]   outReg;
  logic               signOutReg;
  logic               ovfReg;

  logic               ovfNext;
  logic [2*WIDTH-1:0] magNext;
  logic               signNext;
  logic [OUT_W-1:0]   extMag;
  logic [OUT_W-1:0]   outNext;

  assign start = (stateReg == IDLE) && in_valid;

  shift_add_core #(.WIDTH(WIDTH)) uCore (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .magA   (mag_a),
    .magB   (mag_b),
    .product(coreProduct),
    .done   (coreDone)
  );

  // Negative zero is normalised so a zero product always reports sign=0.
  always_comb begin
    ovfNext  = coreProduct > MaxMag;
    magNext  = (SATURATE && ovfNext) ? MaxMag : coreProduct;
    signNext = signReg && (magNext != '0);
    extMag   = OUT_W'(magNext);
    outNext  = signNext ? -extMag : extMag;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateReg   <= IDLE;
      signReg    <= 1'b0;
      outReg     <= '0;
      signOutReg <= 1'b0;
      ovfReg     <= 1'b0;
    end else begin
      stateReg <= stateNext;
      if (start) signReg <= sign_a ^ sign_b;
      if ((stateReg == BUSY) && coreDone) begin
        outReg     <= outNext;
        signOutReg <= signNext;
        ovfReg     <= ovfNext;
      end
    end
  end

  always_comb begin
    stateNext = stateReg;
    in_ready  = 1'b0;
    busy      = 1'b0;
    out_valid = 1'b0;
    case (stateReg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) stateNext = BUSY;
      end
      BUSY: begin
        busy = 1'b1;
        if (coreDone) stateNext = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  assign out      = outReg;
  assign sign     = signOutReg;
  assign overflow = ovfReg;

endmodule

// File: tb/tb_signmag_mul_seq.sv
// Self-checking bench: directed cases on WIDTH=7 (both SATURATE values) and a
// scoreboarded random run on WIDTH=12/OVF_W=20 (both SATURATE values).
module tb_signmag_mul_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // WIDTH=7 pair, shared stimulus
  logic       inV7, outRdy7, sa7, sb7;
  logic [6:0] a7, b7;
  logic       inRdy7 [2];
  logic       outV7  [2];
  logic       sign7  [2];
  logic       ovf7   [2];
  logic       busy7  [2];
  logic [31:0] out7  [2];

  // WIDTH=12 pair, shared stimulus
  logic        inV12, outRdy12, sa12, sb12;
  logic [11:0] a12, b12;
  logic        inRdy12 [2];
  logic        outV12  [2];
  logic        sign12  [2];
  logic        ovf12   [2];
  logic        busy12  [2];
  logic [31:0] out12   [2];

  signmag_mul_seq #(.WIDTH(7), .OUT_W(32), .OVF_W(12), .SATURATE(1'b0)) d7s0 (
    .clk(clk), .rst(rst), .in_valid(inV7), .in_ready(inRdy7[0]),
    .mag_a(a7), .sign_a(sa7), .mag_b(b7), .sign_b(sb7),
    .out_valid(outV7[0]), .out_ready(outRdy7), .out(out7[0]),
    .sign(sign7[0]), .overflow(ovf7[0]), .busy(busy7[0]));

  signmag_mul_seq #(.WIDTH(7), .OUT_W(32), .OVF_W(12), .SATURATE(1'b1)) d7s1 (
    .clk(clk), .rst(rst), .in_valid(inV7), .in_ready(inRdy7[1]),
    .mag_a(a7), .sign_a(sa7), .mag_b(b7), .sign_b(sb7),
    .out_valid(outV7[1]), .out_ready(outRdy7), .out(out7[1]),
    .sign(sign7[1]), .overflow(ovf7[1]), .busy(busy7[1]));

  signmag_mul_seq #(.WIDTH(12), .OUT_W(32), .OVF_W(20), .SATURATE(1'b0)) d12s0 (
    .clk(clk), .rst(rst), .in_valid(inV12), .in_ready(inRdy12[0]),
    .mag_a(a12), .sign_a(sa12), .mag_b(b12), .sign_b(sb12),
    .out_valid(outV12[0]), .out_ready(outRdy12), .out(out12[0]),
    .sign(sign12[0]), .overflow(ovf12[0]), .busy(busy12[0]));

  signmag_mul_seq #(.WIDTH(12), .OUT_W(32), .OVF_W(20), .SATURATE(1'b1)) d12s1 (
    .clk(clk), .rst(rst), .in_valid(inV12), .in_ready(inRdy12[1]),
    .mag_a(a12), .sign_a(sa12), .mag_b(b12), .sign_b(sb12),
    .out_valid(outV12[1]), .out_ready(outRdy12), .out(out12[1]),
    .sign(sign12[1]), .overflow(ovf12[1]), .busy(busy12[1]));

  int testsRun = 0;
  int failures = 0;

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    testsRun++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Returns {overflow, sign, out[31:0]}
  function automatic logic [33:0] model(input int ovfW, input bit sat, input longint a,
                                        input bit sa, input longint b, input bit sb);
    longint p, lim, m, v;
    bit ovf, s;
    p   = a * b;
    lim = (longint'(1) << ovfW) - 1;
    ovf = p > lim;
    m   = (sat && ovf) ? lim : p;
    s   = (sa ^ sb) && (m != 0);
    v   = s ? -m : m;
    return {ovf, s, v[31:0]};
  endfunction

  typedef struct {
    int          id;
    logic [33:0] e0;
    logic [33:0] e1;
  } expT;

  expT sbQ[$];

  task automatic op7(input logic [6:0] a, input logic sa, input logic [6:0] b, input logic sb,
                     output int lat);
    @(negedge clk);
    a7 = a; sa7 = sa; b7 = b; sb7 = sb; inV7 = 1'b1;
    @(posedge clk);
    #1;
    inV7 = 1'b0;
    checkVal("busy_after_accept", busy7[0], 1);
    checkVal("in_ready_busy", inRdy7[0], 0);
    lat = 0;
    while (!outV7[0] && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic checkRes7(input string tag, input logic [6:0] a, input logic sa,
                           input logic [6:0] b, input logic sb);
    logic [33:0] e0, e1;
    e0 = model(12, 1'b0, longint'(a), sa, longint'(b), sb);
    e1 = model(12, 1'b1, longint'(b) * 0 + longint'(a), sa, longint'(b), sb);
    checkVal({tag, "_out_s0"}, out7[0], e0[31:0]);
    checkVal({tag, "_sign_s0"}, sign7[0], e0[32]);
    checkVal({tag, "_ovf_s0"}, ovf7[0], e0[33]);
    checkVal({tag, "_out_s1"}, out7[1], e1[31:0]);
    checkVal({tag, "_sign_s1"}, sign7[1], e1[32]);
    checkVal({tag, "_ovf_s1"}, ovf7[1], e1[33]);
    $display("[TB] %s: %0d%s * %0d%s -> s0 %08h s1 %08h", tag, a, sa ? "-" : "+", b,
             sb ? "-" : "+", out7[0], out7[1]);
  endtask

  task automatic handshake7(input string tag);
    @(negedge clk);
    outRdy7 = 1'b1;
    @(posedge clk);
    #1;
    outRdy7 = 1'b0;
    checkVal({tag, "_valid_drop"}, outV7[0], 0);
    checkVal({tag, "_in_ready_back"}, inRdy7[0], 1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int accepted, retired, cycles;
    logic [33:0] e0;
    logic [31:0] heldOut;
    expT ent;

    rst = 1'b1;
    inV7 = 0; outRdy7 = 0; sa7 = 0; sb7 = 0; a7 = '0; b7 = '0;
    inV12 = 0; outRdy12 = 0; sa12 = 0; sb12 = 0; a12 = '0; b12 = '0;
    repeat (2) @(posedge clk);
    #1;
    checkVal("rst_in_ready", inRdy7[0], 1);
    checkVal("rst_out_valid", outV7[0], 0);
    checkVal("rst_busy", busy7[0], 0);
    checkVal("rst_out", out7[0], 0);
    checkVal("rst_sign", sign7[0], 0);
    checkVal("rst_ovf", ovf7[0], 0);
    @(negedge clk);
    rst = 1'b0;

    // 1: basic latency and negative result
    op7(7'd5, 1'b0, 7'd3, 1'b1, lat);
    checkVal("t1_latency", lat, 8);
    checkVal("t1_out", out7[0], 32'hFFFF_FFF1);
    checkVal("t1_sign", sign7[0], 1);
    checkVal("t1_ovf", ovf7[0], 0);
    checkRes7("t1", 7'd5, 1'b0, 7'd3, 1'b1);
    handshake7("t1");

    // 2: largest magnitudes, with and without saturation
    op7(7'd127, 1'b0, 7'd127, 1'b0, lat);
    checkVal("t2_out_s0", out7[0], 32'h0000_3F01);
    checkVal("t2_ovf_s0", ovf7[0], 1);
    checkVal("t2_out_s1", out7[1], 32'h0000_0FFF);
    checkVal("t2_ovf_s1", ovf7[1], 1);
    checkVal("t2_sign_s1", sign7[1], 0);
    handshake7("t2");

    // 3: negative zero normalisation and double negative
    op7(7'd0, 1'b0, 7'd9, 1'b1, lat);
    checkVal("t3a_out", out7[0], 32'h0);
    checkVal("t3a_sign", sign7[0], 0);
    checkVal("t3a_ovf", ovf7[0], 0);
    checkRes7("t3a", 7'd0, 1'b0, 7'd9, 1'b1);
    handshake7("t3a");
    op7(7'd127, 1'b1, 7'd1, 1'b1, lat);
    checkVal("t3b_out", out7[0], 32'h0000_007F);
    checkVal("t3b_sign", sign7[0], 0);
    checkRes7("t3b", 7'd127, 1'b1, 7'd1, 1'b1);
    handshake7("t3b");

    // 4: back-pressure with changing inputs
    op7(7'd100, 1'b1, 7'd50, 1'b0, lat);
    e0 = model(12, 1'b0, 100, 1'b1, 50, 1'b0);
    checkRes7("t4", 7'd100, 1'b1, 7'd50, 1'b0);
    heldOut = e0[31:0];
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      a7 = 7'($urandom_range(0, 127)); b7 = 7'($urandom_range(0, 127));
      sa7 = 1'($urandom_range(0, 1)); sb7 = 1'($urandom_range(0, 1));
      inV7 = 1'b1;
      @(posedge clk);
      #1;
      checkVal("t4_hold_out", out7[0], heldOut);
      checkVal("t4_hold_sign", sign7[0], 1);
      checkVal("t4_hold_valid", outV7[0], 1);
      checkVal("t4_hold_in_ready", inRdy7[0], 0);
    end
    inV7 = 1'b0;
    handshake7("t4");
    checkVal("t4_keep_out", out7[0], heldOut);
    checkVal("t4_keep_ovf", ovf7[0], 1);

    // 5: asynchronous reset during BUSY
    @(negedge clk);
    a7 = 7'd20; sa7 = 1'b0; b7 = 7'd20; sb7 = 1'b0; inV7 = 1'b1;
    @(posedge clk);
    #1;
    inV7 = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    checkVal("t5_busy_before", busy7[0], 1);
    rst = 1'b1;
    #1;
    checkVal("t5_rst_out", out7[0], 0);
    checkVal("t5_rst_sign", sign7[0], 0);
    checkVal("t5_rst_ovf", ovf7[0], 0);
    checkVal("t5_rst_valid", outV7[0], 0);
    checkVal("t5_rst_in_ready", inRdy7[0], 1);
    checkVal("t5_rst_busy", busy7[0], 0);
    @(negedge clk);
    rst = 1'b0;
    op7(7'd6, 1'b0, 7'd7, 1'b1, lat);
    checkVal("t5_latency", lat, 8);
    checkVal("t5_out", out7[0], 32'hFFFF_FFD6);
    checkRes7("t5", 7'd6, 1'b0, 7'd7, 1'b1);
    handshake7("t5");

    // 6: random back-to-back traffic against the scoreboard
    accepted = 0; retired = 0; cycles = 0;
    while ((accepted < 500 || sbQ.size() > 0) && cycles < 20000) begin
      @(posedge clk);
      #1;
      inV12 = (accepted < 500) && ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 7))
        0: a12 = 12'hFFF;
        1: a12 = 12'h000;
        default: a12 = 12'($urandom_range(0, 4095));
      endcase
      case ($urandom_range(0, 7))
        0: b12 = 12'hFFF;
        1: b12 = 12'h000;
        default: b12 = 12'($urandom_range(0, 4095));
      endcase
      sa12 = 1'($urandom_range(0, 1));
      sb12 = 1'($urandom_range(0, 1));
      outRdy12 = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (inV12 && inRdy12[0]) begin
        ent.id = accepted;
        ent.e0 = model(20, 1'b0, longint'(a12), sa12, longint'(b12), sb12);
        ent.e1 = model(20, 1'b1, longint'(a12), sa12, longint'(b12), sb12);
        sbQ.push_back(ent);
        accepted++;
      end
      if (outV12[0] && outRdy12) begin
        if (sbQ.size() == 0) begin
          checkVal("t6_spurious_result", 1, 0);
        end else begin
          ent = sbQ.pop_front();
          checkVal("t6_out_s0", out12[0], ent.e0[31:0]);
          checkVal("t6_sign_s0", sign12[0], ent.e0[32]);
          checkVal("t6_ovf_s0", ovf12[0], ent.e0[33]);
          checkVal("t6_out_s1", out12[1], ent.e1[31:0]);
          checkVal("t6_sign_s1", sign12[1], ent.e1[32]);
          checkVal("t6_ovf_s1", ovf12[1], ent.e1[33]);
          $display("[TB] t6 op %0d: s0 %08h s1 %08h", ent.id, out12[0], out12[1]);
        end
        retired++;
      end
      cycles++;
    end
    checkVal("t6_accepted", accepted, 500);
    checkVal("t6_retired", retired, 500);

    $display("[TB] %0d tests run, %0d failed", testsRun, failures);
    $finish;
  end

endmodule
